// File: rtl/i2s_pkg.sv
// Shared constants and parameter-legality helper for the I2S transmit path.
package i2s_pkg;

  localparam int   SLOT_BITS  = 32;
  localparam int   FRAME_BITS = 64;
  localparam int   BIT_IDX_W  = $clog2(FRAME_BITS);
  localparam logic WS_LEFT    = 1'b0;

  function automatic bit i2s_params_legal(input int sample_width, input int sck_half);
    return (sample_width >= 1) && (sample_width <= SLOT_BITS) && (sck_half >= 2);
  endfunction

endpackage

// File: rtl/i2s_sck_gen.sv
// SCK divider: toggles the bit clock every SCK_HALF clk cycles and flags the
// cycle whose closing edge produces an SCK rise or fall.
`timescale 1ns/1ps
module i2s_sck_gen #(
  parameter int SCK_HALF = 4
) (
  input  logic clk,
  input  logic reset,
  output logic o_sck,
  output logic o_sck_rise,
  output logic o_sck_fall
);

  localparam int CNT_W = (SCK_HALF > 2) ? $clog2(SCK_HALF) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_sck;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(SCK_HALF - 1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
      r_sck <= 1'b0;
    end else if (w_wrap) begin
      r_cnt <= '0;
      r_sck <= ~r_sck;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_sck      = r_sck;
  assign o_sck_rise = w_wrap && !r_sck;
  assign o_sck_fall = w_wrap && r_sck;

endmodule

// File: rtl/i2s_transmitter.sv
// Philips I2S bus master: 64-SCK frames, 32-bit slots, MSB-first, fed by a
// one-frame holding register behind a valid/ready handshake.
`timescale 1ns/1ps
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 24,
  parameter int SCK_HALF     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SAMPLE_WIDTH-1:0] SAMPLE_L,
  input  logic [SAMPLE_WIDTH-1:0] SAMPLE_R,
  input  logic                    SAMPLE_VALID,
  output logic                    SAMPLE_READY,
  output logic                    SCK,
  output logic                    WS,
  output logic                    SD,
  output logic                    UNDERRUN
);

  if (!i2s_params_legal(SAMPLE_WIDTH, SCK_HALF)) begin : g_param_check
    $error("i2s_transmitter: illegal SAMPLE_WIDTH=%0d / SCK_HALF=%0d", SAMPLE_WIDTH, SCK_HALF);
  end

  localparam logic [BIT_IDX_W-1:0] LAST_BIT   = BIT_IDX_W'(FRAME_BITS - 1);
  localparam logic [BIT_IDX_W-1:0] WS_R_FIRST = BIT_IDX_W'(SLOT_BITS - 1);
  localparam logic [BIT_IDX_W-1:0] WS_R_LAST  = BIT_IDX_W'(FRAME_BITS - 2);
  localparam int                   PAD_BITS   = SLOT_BITS - SAMPLE_WIDTH;

  logic                    w_sck_rise;
  logic                    w_sck_fall;
  logic                    w_load;
  logic                    w_accept;
  logic                    w_ws_next;
  logic [BIT_IDX_W-1:0]    w_next_idx;
  logic [SLOT_BITS-1:0]    w_slot_l;
  logic [SLOT_BITS-1:0]    w_slot_r;

  logic [BIT_IDX_W-1:0]    r_bit_idx;
  logic [FRAME_BITS-1:0]   r_shift;
  logic                    r_ws;
  logic                    r_underrun;
  logic                    r_hold_full;
  logic [SAMPLE_WIDTH-1:0] r_hold_l;
  logic [SAMPLE_WIDTH-1:0] r_hold_r;

  i2s_sck_gen #(
    .SCK_HALF   (SCK_HALF)
  ) u_sck_gen (
    .clk        (clk),
    .reset      (reset),
    .o_sck      (SCK),
    .o_sck_rise (w_sck_rise),
    .o_sck_fall (w_sck_fall)
  );

  // The bit logic advances only on falls; a strobe collision would mean a broken divider.
  assert property (@(posedge clk) disable iff (!reset) !(w_sck_rise && w_sck_fall));

  assign w_next_idx = r_bit_idx + 1'b1;
  assign w_load     = w_sck_fall && (r_bit_idx == LAST_BIT);
  assign w_accept   = SAMPLE_VALID && !r_hold_full;
  assign w_ws_next  = ((w_next_idx >= WS_R_FIRST) && (w_next_idx <= WS_R_LAST)) ? ~WS_LEFT : WS_LEFT;

  // Samples are left-justified in their slot; the tail of each slot is zero.
  assign w_slot_l = SLOT_BITS'(r_hold_l) << PAD_BITS;
  assign w_slot_r = SLOT_BITS'(r_hold_r) << PAD_BITS;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold_full <= 1'b1;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end
  end

  // NOTE: the sample data registers carry no reset; r_hold_full alone says
  // whether their contents are meaningful, so clearing them would be wasted logic.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_hold_l <= SAMPLE_L;
      r_hold_r <= SAMPLE_R;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bit_idx  <= LAST_BIT;
      r_shift    <= '0;
      r_ws       <= WS_LEFT;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_load && !r_hold_full;
      if (w_sck_fall) begin
        r_bit_idx <= w_next_idx;
        r_ws      <= w_ws_next;
        if (w_load) begin
          r_shift <= r_hold_full ? {w_slot_l, w_slot_r} : '0;
        end else begin
          r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
        end
      end
    end
  end

  assign SAMPLE_READY = !r_hold_full;
  assign WS           = r_ws;
  assign SD           = r_shift[FRAME_BITS-1];
  assign UNDERRUN     = r_underrun;

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter: reset, single pair, underrun, streaming,
// accept-on-load collision, mid-frame reset and the 32-bit width boundary.
`timescale 1ns/1ps
module tb_i2s_transmitter;

  localparam int          SCK_HALF  = 4;
  localparam int          BIT_CYC   = 2 * SCK_HALF;
  localparam int          FRAME_CYC = 64 * BIT_CYC;
  localparam int          N_STREAM  = 100;
  localparam logic [63:0] WS_EXP    = 64'h0000_0001_FFFF_FFFE;

  typedef struct {
    logic [63:0] sd;
    logic [63:0] ws;
    int          und;
    int          rdy;
    int          start;
    int          ws_rise;
    int          ws_fall;
    bit          ok;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] l_a, r_a;
  logic        valid_a, ready_a, sck_a, ws_a, sd_a, und_a;
  logic [31:0] l_b, r_b;
  logic        valid_b, ready_b, sck_b, ws_b, sd_b, und_b;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          n_a, n_b;
  logic        prev_sck_a, prev_sck_b;
  bit          rise_a, fall_a, rise_b, fall_b;
  bit          stream_on  = 0;
  bit          hs_pending = 0;
  logic [23:0] stream_k;
  int          sim_cyc    = -10;
  logic [23:0] sim_l, sim_r;

  i2s_transmitter u_dut_a (
    .clk          (clk),
    .reset        (reset),
    .SAMPLE_L     (l_a),
    .SAMPLE_R     (r_a),
    .SAMPLE_VALID (valid_a),
    .SAMPLE_READY (ready_a),
    .SCK          (sck_a),
    .WS           (ws_a),
    .SD           (sd_a),
    .UNDERRUN     (und_a)
  );

  i2s_transmitter #(
    .SAMPLE_WIDTH (32),
    .SCK_HALF     (SCK_HALF)
  ) u_dut_b (
    .clk          (clk),
    .reset        (reset),
    .SAMPLE_L     (l_b),
    .SAMPLE_R     (r_b),
    .SAMPLE_VALID (valid_b),
    .SAMPLE_READY (ready_b),
    .SCK          (sck_b),
    .WS           (ws_b),
    .SD           (sd_b),
    .UNDERRUN     (und_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next falling clk edge and update the bench's SCK/bit trackers.
  task automatic tick();
    @(negedge clk);
    cyc++;
    rise_a = !prev_sck_a && sck_a;
    fall_a = prev_sck_a && !sck_a;
    prev_sck_a = sck_a;
    rise_b = !prev_sck_b && sck_b;
    fall_b = prev_sck_b && !sck_b;
    prev_sck_b = sck_b;
    if (fall_a) n_a = (n_a + 1) % 64;
    if (fall_b) n_b = (n_b + 1) % 64;
    if (stream_on) begin
      if (hs_pending) begin
        stream_k++;
        l_a = stream_k;
        r_a = ~stream_k;
      end
      hs_pending = valid_a && ready_a;
    end
    if (cyc == sim_cyc) begin
      valid_a = 1'b1;
      l_a     = sim_l;
      r_a     = sim_r;
    end else if (cyc == sim_cyc + 1) begin
      valid_a = 1'b0;
    end
  endtask

  task automatic send_pair(input bit sel, input logic [31:0] l, input logic [31:0] r);
    bit acc;
    bit cur_ready;
    int guard;
    if (sel) begin l_b = l; r_b = r; valid_b = 1'b1; end
    else begin l_a = l[23:0]; r_a = r[23:0]; valid_a = 1'b1; end
    acc = 0;
    guard = 0;
    while (!acc && guard < 2 * FRAME_CYC) begin
      cur_ready = sel ? ready_b : ready_a;
      tick();
      guard++;
      if (cur_ready) acc = 1;
    end
    if (sel) valid_b = 1'b0;
    else valid_a = 1'b0;
    check("pair_accepted", 64'(acc), 64'd1);
  endtask

  task automatic wait_rise_a(input int n);
    bit found;
    int guard;
    found = 0;
    guard = 0;
    while (!found && guard < 2 * FRAME_CYC) begin
      tick();
      guard++;
      found = rise_a && (n_a == n);
    end
    check("bit_rise_reached", 64'(found), 64'd1);
  endtask

  // Captures one frame, starting at its load edge, sampling SD/WS on SCK rises.
  task automatic get_frame(input bit sel, output frame_t f);
    bit   found, done, r, s, w, u, rd, prev_ws;
    int   guard, n;
    f.sd = '0; f.ws = '0; f.und = 0; f.rdy = 0;
    f.start = -1; f.ws_rise = -1; f.ws_fall = -1; f.ok = 0;
    found = 0;
    guard = 0;
    while (!found && guard < 2 * FRAME_CYC) begin
      tick();
      guard++;
      found = sel ? (fall_b && n_b == 0) : (fall_a && n_a == 0);
    end
    check("frame_start_seen", 64'(found), 64'd1);
    if (!found) return;
    f.start = cyc;
    prev_ws = sel ? ws_b : ws_a;
    done  = 0;
    guard = 0;
    while (!done && guard < FRAME_CYC + BIT_CYC) begin
      r  = sel ? rise_b  : rise_a;
      s  = sel ? sd_b    : sd_a;
      w  = sel ? ws_b    : ws_a;
      u  = sel ? und_b   : und_a;
      rd = sel ? ready_b : ready_a;
      n  = sel ? n_b     : n_a;
      f.und += int'(u);
      f.rdy += int'(rd);
      if (w && !prev_ws) f.ws_rise = cyc;
      if (!w && prev_ws) f.ws_fall = cyc;
      prev_ws = w;
      if (r) begin
        f.sd[63-n] = s;
        f.ws[63-n] = w;
        if (n == 63) done = 1;
      end
      if (!done) begin
        tick();
        guard++;
      end
    end
    check("frame_end_seen", 64'(done), 64'd1);
    f.ok = done;
  endtask

  task automatic check_reset_outputs();
    check("rst_sck",   64'(sck_a),   64'd0);
    check("rst_ws",    64'(ws_a),    64'd0);
    check("rst_sd",    64'(sd_a),    64'd0);
    check("rst_ready", 64'(ready_a), 64'd1);
    check("rst_und",   64'(und_a),   64'd0);
    check("rst_sck_b", 64'(sck_b),   64'd0);
    check("rst_ws_b",  64'(ws_b),    64'd0);
  endtask

  // Releases reset on a falling clk edge and checks the first SCK rise/fall and frame load.
  task automatic release_and_check();
    repeat (2) @(negedge clk);
    reset      = 1'b1;
    cyc        = 0;
    n_a        = 63;
    n_b        = 63;
    prev_sck_a = sck_a;
    prev_sck_b = sck_b;
    stream_on  = 0;
    hs_pending = 0;
    sim_cyc    = -10;
    repeat (3) tick();
    check("sck_low_cycle3", 64'(sck_a), 64'd0);
    tick();
    check("sck_rise_cycle4", 64'(sck_a), 64'd1);
    check("sck_b_rise_cycle4", 64'(sck_b), 64'd1);
    repeat (3) tick();
    check("sck_high_cycle7", 64'(sck_a), 64'd1);
    tick();
    check("first_fall_cycle8", 64'(fall_a), 64'd1);
    check("first_load_underrun", 64'(und_a), 64'd1);
    check("first_load_sd", 64'(sd_a), 64'd0);
    check("first_load_ws", 64'(ws_a), 64'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no end of test, expected completion within 3 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    frame_t      f;
    int          prev_start;
    logic [23:0] ek;

    reset   = 1'b1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    l_a = '0; r_a = '0; l_b = '0; r_b = '0;
    #3 reset = 1'b0;
    #1 check_reset_outputs();
    release_and_check();

    // Single pair, accepted well before the next load.
    send_pair(0, 32'h00A5A5A5, 32'h005A5A5A);
    check("ready_low_after_accept", 64'(ready_a), 64'd0);
    get_frame(0, f);
    check("pair_frame_start", 64'(f.start), 64'(8 + FRAME_CYC));
    check("pair_sd", f.sd, {24'hA5A5A5, 8'h00, 24'h5A5A5A, 8'h00});
    check("pair_ws", f.ws, WS_EXP);
    check("pair_no_underrun", 64'(f.und), 64'd0);
    prev_start = f.start;

    // Idle upstream: one underrun pulse per frame, silent data, WS keeps running.
    for (int i = 0; i < 2; i++) begin
      get_frame(0, f);
      check("idle_period", 64'(f.start - prev_start), 64'(FRAME_CYC));
      check("idle_underrun_pulses", 64'(f.und), 64'd1);
      check("idle_sd", f.sd, 64'd0);
      check("idle_ws", f.ws, WS_EXP);
      check("idle_ws_rise_offset", 64'(f.ws_rise - f.start), 64'(31 * BIT_CYC));
      check("idle_ws_half_period", 64'(f.ws_fall - f.ws_rise), 64'(FRAME_CYC / 2));
      prev_start = f.start;
    end

    // Streaming: VALID held high with L = k, R = ~k.
    stream_k   = 24'd1;
    l_a        = 24'd1;
    r_a        = ~24'd1;
    valid_a    = 1'b1;
    hs_pending = ready_a;
    stream_on  = 1;
    for (int j = 0; j < N_STREAM; j++) begin
      get_frame(0, f);
      ek = 24'(j + 1);
      check("stream_sd", f.sd, {ek, 8'h00, ~ek, 8'h00});
      check("stream_no_underrun", 64'(f.und), 64'd0);
      check("stream_ready_one_cycle", 64'(f.rdy), 64'd1);
    end
    stream_on = 0;
    valid_a   = 1'b0;

    // The pair already held when streaming stopped goes out next.
    get_frame(0, f);
    ek = 24'(N_STREAM + 1);
    check("drain_sd", f.sd, {ek, 8'h00, ~ek, 8'h00});
    check("drain_no_underrun", 64'(f.und), 64'd0);
    prev_start = f.start;

    // VALID presented exactly on the load edge with the holding register empty.
    sim_l   = 24'h123456;
    sim_r   = 24'hC3C3C3;
    sim_cyc = prev_start + FRAME_CYC - 1;
    get_frame(0, f);
    check("collide_period", 64'(f.start - prev_start), 64'(FRAME_CYC));
    check("collide_underrun", 64'(f.und), 64'd1);
    check("collide_sd_zero", f.sd, 64'd0);
    check("collide_ready_held_low", 64'(f.rdy), 64'd0);
    get_frame(0, f);
    check("collide_next_sd", f.sd, {24'h123456, 8'h00, 24'hC3C3C3, 8'h00});
    check("collide_next_no_underrun", 64'(f.und), 64'd0);

    // Mid-frame reset at n = 40 with data on SD, WS high and the holding register full.
    send_pair(0, 32'h000F0F0F, 32'h0000FF00);
    wait_rise_a(0);
    send_pair(0, 32'h00777777, 32'h00777777);
    wait_rise_a(40);
    check("pre_reset_sd", 64'(sd_a), 64'd1);
    check("pre_reset_ws", 64'(ws_a), 64'd1);
    check("pre_reset_ready", 64'(ready_a), 64'd0);
    #2 reset = 1'b0;
    #1 check_reset_outputs();
    release_and_check();

    // 32-bit samples fill the whole slot; WS must still lead the right MSB by one bit.
    send_pair(1, 32'h80000001, 32'h00000001);
    get_frame(1, f);
    check("w32_frame_start", 64'(f.start), 64'(8 + FRAME_CYC));
    check("w32_sd", f.sd, 64'h80000001_00000001);
    check("w32_ws", f.ws, WS_EXP);
    check("w32_bit0", 64'(f.sd[63]), 64'd1);
    check("w32_bit31", 64'(f.sd[32]), 64'd1);
    check("w32_ws_bit31", 64'(f.ws[32]), 64'd1);
    check("w32_ws_bit30", 64'(f.ws[33]), 64'd0);
    check("w32_no_underrun", 64'(f.und), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
